// File: rtl/mant_align_shifter_if.sv
// Operand/result handshake bundle for the mantissa alignment shifter.
// The slave modport is the shifter; the master side is upstream plus downstream.
interface mant_align_shifter_if #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [SHW-1:0]   in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic             out_sticky;

    modport master (
        output in_valid,
        input  in_ready,
        output in_mant,
        output in_shamt,
        input  out_valid,
        output out_ready,
        input  out_mant,
        input  out_sticky
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_mant,
        input  in_shamt,
        output out_valid,
        input  out_ready,
        output out_mant,
        output out_sticky
    );
endinterface

// File: rtl/mant_align_shifter.sv
// Multi-cycle logarithmic right shifter with sticky: one log-stage per cycle,
// fixed five-cycle SHIFT phase regardless of shift amount.
module mant_align_shifter #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned SHW   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mant_align_shifter_if.slave   bus,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [2:0] LastStage = 3'(SHW - 1);

    state_e           state_q;
    logic [WIDTH-1:0] mant_q;
    logic [SHW-1:0]   shamt_q;
    logic             sticky_q;
    logic [2:0]       stage_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // 2^k is both the one-hot select of shamt bit k and the stage-k shift distance.
    logic [SHW-1:0]   stage_onehot;
    logic             stage_active;
    logic [WIDTH-1:0] mant_shifted;
    logic             lost_bits;

    always_comb begin
        stage_onehot = SHW'(1) << stage_q;
        stage_active = |(shamt_q & stage_onehot);
        mant_shifted = mant_q >> stage_onehot;
        lost_bits    = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(stage_onehot)) begin
                lost_bits = lost_bits | mant_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mant_q      <= '0;
            shamt_q     <= '0;
            sticky_q    <= 1'b0;
            stage_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        mant_q      <= bus.in_mant;
                        shamt_q     <= bus.in_shamt;
                        sticky_q    <= 1'b0;
                        stage_q     <= '0;
                        state_q     <= StShift;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                StShift: begin
                    if (stage_active) begin
                        mant_q   <= mant_shifted;
                        sticky_q <= sticky_q | lost_bits;
                    end
                    stage_q <= stage_q + 3'd1;
                    if (stage_q == LastStage) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_mant   = mant_q;
    assign bus.out_sticky = sticky_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_mant_align_shifter.sv
// Directed bench for mant_align_shifter: vector table plus hold and
// mid-operation reset sequences.
module tb_mant_align_shifter;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mant_align_shifter_if #(.WIDTH(11), .SHW(5)) bus ();

    mant_align_shifter #(.WIDTH(11), .SHW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        logic [10:0] mant;
        logic [4:0]  shamt;
        logic [10:0] exp_mant;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand at the next edge, then wait for DONE and check the result.
    task automatic accept_and_wait(input logic [10:0] m, input logic [4:0] s,
                                   input logic [10:0] em, input logic es, input string nm);
        int lat;
        bus.in_mant   = m;
        bus.in_shamt  = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        chk({nm, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_mant  = ~m;
        bus.in_shamt = ~s;
        chk({nm, " in_ready shift"}, 32'(bus.in_ready), 32'd0);
        chk({nm, " busy shift"}, 32'(busy), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd5);
        chk({nm, " out_mant"}, 32'(bus.out_mant), 32'(em));
        chk({nm, " out_sticky"}, 32'(bus.out_sticky), 32'(es));
    endtask

    task automatic drain(input string nm);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, " out_valid after drain"}, 32'(bus.out_valid), 32'd0);
        chk({nm, " in_ready after drain"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{11'h7FF, 5'd0,  11'h7FF, 1'b0};
        vecs[1]  = '{11'h400, 5'd3,  11'h080, 1'b0};
        vecs[2]  = '{11'h405, 5'd2,  11'h101, 1'b1};
        vecs[3]  = '{11'h001, 5'd31, 11'h000, 1'b1};
        vecs[4]  = '{11'h000, 5'd20, 11'h000, 1'b0};
        vecs[5]  = '{11'h7FF, 5'd11, 11'h000, 1'b1};
        vecs[6]  = '{11'h555, 5'd1,  11'h2AA, 1'b1};
        vecs[7]  = '{11'h2AA, 5'd1,  11'h155, 1'b0};
        vecs[8]  = '{11'h7FF, 5'd10, 11'h001, 1'b1};
        vecs[9]  = '{11'h400, 5'd10, 11'h001, 1'b0};
        vecs[10] = '{11'h123, 5'd4,  11'h012, 1'b1};
        vecs[11] = '{11'h3F0, 5'd4,  11'h03F, 1'b0};
        vecs[12] = '{11'h001, 5'd0,  11'h001, 1'b0};
        vecs[13] = '{11'h7FF, 5'd5,  11'h03F, 1'b1};
        vecs[14] = '{11'h400, 5'd16, 11'h000, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset out_mant", 32'(bus.out_mant), 32'd0);
        chk("reset out_sticky", 32'(bus.out_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First vector is offered immediately so it lands on the first edge after release.
        for (int i = 0; i < 15; i++) begin
            accept_and_wait(vecs[i].mant, vecs[i].shamt, vecs[i].exp_mant,
                            vecs[i].exp_sticky, $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Hold result in DONE while upstream keeps poking the inputs.
        accept_and_wait(11'h405, 5'd2, 11'h101, 1'b1, "hold");
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            bus.in_mant  = 11'(c * 37);
            bus.in_shamt = 5'(c);
            tick();
            chk($sformatf("hold%0d out_mant", c), 32'(bus.out_mant), 32'h101);
            chk($sformatf("hold%0d out_sticky", c), 32'(bus.out_sticky), 32'd1);
            chk($sformatf("hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        drain("hold");
        chk("hold busy idle", 32'(busy), 32'd0);
        tick();
        tick();
        chk("idle keeps out_mant", 32'(bus.out_mant), 32'h101);
        chk("idle keeps out_sticky", 32'(bus.out_sticky), 32'd1);
        chk("idle no accept", 32'(busy), 32'd0);

        // Reset during the third SHIFT cycle discards the operation.
        bus.in_mant  = 11'h3FF;
        bus.in_shamt = 5'd4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_mant", 32'(bus.out_mant), 32'd0);
        chk("midreset out_sticky", 32'(bus.out_sticky), 32'd0);
        chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
        chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (bus.out_valid) seen++;
            end
            chk("no result after reset", 32'(seen), 32'd0);
        end
        accept_and_wait(11'h3FF, 5'd4, 11'h03F, 1'b1, "post-reset");
        drain("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mant_align_shifter.md
MANT_ALIGN_SHIFTER -- requirements
Module: mant_align_shifter

Interface
REQ-001 Parameter WIDTH, default 11, mantissa width; 11 is the only supported value.
REQ-002 Parameter SHW, default 5, shift-amount width; 5 is the only supported value.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream offers an operand.
REQ-006 in_ready  output  1  block accepts an operand.
REQ-007 in_mant  input  11  mantissa, hidden bit included, unsigned.
REQ-008 in_shamt  input  5  right-shift amount, 0..31.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_mant  output  11  aligned mantissa.
REQ-012 out_sticky  output  1  OR of all bits shifted out.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-016 In IDLE, in_valid=1 at a rising edge SHALL load mant_reg<=in_mant, shamt_reg<=in_shamt, sticky_reg<=0, stage<=0, and move to SHIFT.
REQ-017 In IDLE, in_valid=0 SHALL leave all registers unchanged.
REQ-018 In SHIFT, each cycle SHALL process log-stage k=stage (0..4).
  - If shamt_reg[k]=1: mant_reg<=mant_reg>>2^k and sticky_reg|=OR of the 2^k bits shifted out.
  - If shamt_reg[k]=0: mant_reg and sticky_reg hold.
  - stage increments.
REQ-019 After stage 4 is processed, the FSM SHALL enter DONE; SHIFT always lasts exactly 5 cycles, independent of shamt.
REQ-020 out_valid SHALL be 1 only in DONE, first asserting 5 rising edges after the accepting edge.
REQ-021 In DONE, out_mant and out_sticky SHALL stay stable until out_ready=1 at a rising edge; that edge returns the FSM to IDLE.
REQ-022 in_valid, in_mant and in_shamt SHALL be ignored in SHIFT and DONE.
REQ-023 The minimum accept-to-accept interval SHALL be 7 cycles: accept, 5 SHIFT cycles, 1 DONE cycle with out_ready=1.
REQ-024 out_mant SHALL equal in_mant>>in_shamt (logical shift, zero fill).
REQ-025 For in_shamt>=11, out_mant SHALL be 0 and out_sticky SHALL equal the OR of all bits of in_mant.
REQ-026 For in_shamt=0, out_mant SHALL equal in_mant and out_sticky SHALL be 0.
REQ-027 out_sticky SHALL be 1 if and only if any bit of in_mant[min(in_shamt,11)-1:0] is 1.
REQ-028 out_mant and out_sticky SHALL be driven directly from registers, with no combinational path from inputs.
REQ-029 out_valid, in_ready and busy SHALL decode from state only, with no combinational dependency on in_valid or out_ready.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, out_valid=0, in_ready=1, busy=0, out_mant=0, out_sticky=0, stage=0, shamt_reg=0.
REQ-031 Reset asserted during SHIFT or DONE SHALL discard the operation; no result SHALL be presented after release.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n is released.

Verification
REQ-033 in_mant=0x7FF, in_shamt=0 -> out_mant=0x7FF, out_sticky=0; out_valid rises exactly 5 edges after accept.
REQ-034 in_mant=0x400, in_shamt=3 -> out_mant=0x080, out_sticky=0.
REQ-035 in_mant=0x405, in_shamt=2 -> out_mant=0x101, out_sticky=1.
REQ-036 Two operands:
  - in_mant=0x001, in_shamt=31 -> out_mant=0x000, out_sticky=1.
  - in_mant=0x000, in_shamt=20 -> out_mant=0x000, out_sticky=0.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and inputs -> out_mant and out_sticky are stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-038 Assert rst_n=0 at the third SHIFT cycle of in_mant=0x3FF, in_shamt=4 -> outputs zero immediately, in_ready=1; after release no out_valid occurs until a new accept.
